// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU core.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    MUL = 4'd2,
    DIV = 4'd3,
    FLS = 4'd4,
    FRS = 4'd5,
    ROL = 4'd6,
    ROR = 4'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // Opcodes that run on the iterative engine rather than the single-cycle path.
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MUL) || (op == DIV);
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative signed multiply (radix-2 Booth) / divide (non-restoring on magnitudes),
// one step per cycle, exactly WIDTH steps per operation.
module seq_muldiv import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   res,
  output logic                 neg,
  output logic                 dz
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]          cnt;
  logic                   div_r;
  logic                   a_neg;
  logic                   q_neg;
  logic                   b_zero;
  logic [WIDTH-1:0]       a_r;
  // Two guard bits: Booth needs room for acc - MIN_INT, division for 2R +/- D.
  logic signed [WIDTH+1:0] acc, acc_nx, m, sum, shifted;
  logic [WIDTH-1:0]       q, q_nx;
  logic                   qm1, qm1_nx;
  logic [WIDTH-1:0]       r_mag, quot, rem;

  // Magnitude of a two's-complement value; MIN_INT maps onto 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  assign done = busy && (cnt == CW'(WIDTH - 1));

  // Step counter: runs WIDTH cycles after start, abortable by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

  // Operand load on start, one Booth / non-restoring step per busy cycle.
  always_ff @(posedge clk) begin
    if (start) begin
      div_r  <= is_div;
      a_r    <= a;
      a_neg  <= a[WIDTH-1];
      q_neg  <= a[WIDTH-1] ^ b[WIDTH-1];
      b_zero <= (b == '0);
      acc    <= '0;
      qm1    <= 1'b0;
      if (is_div) begin
        q <= mag(a);
        m <= {2'b00, mag(b)};
      end else begin
        q <= a;
        m <= {{2{b[WIDTH-1]}}, b};
      end
    end else if (busy) begin
      acc <= acc_nx;
      q   <= q_nx;
      qm1 <= qm1_nx;
    end
  end

  // Next-step datapath shared by both algorithms.
  always_comb begin
    shifted = '0;
    sum     = acc;
    acc_nx  = acc;
    q_nx    = q;
    qm1_nx  = qm1;
    if (div_r) begin
      shifted = {acc[WIDTH:0], q[WIDTH-1]};
      sum     = acc[WIDTH+1] ? (shifted + m) : (shifted - m);
      acc_nx  = sum;
      q_nx    = {q[WIDTH-2:0], ~sum[WIDTH+1]};
    end else begin
      case ({q[0], qm1})
        2'b01:   sum = acc + m;
        2'b10:   sum = acc - m;
        default: sum = acc;
      endcase
      acc_nx = sum >>> 1;
      q_nx   = {sum[0], q[WIDTH-1:1]};
      qm1_nx = q[0];
    end
  end

  // Result of the final step: remainder correction, sign fix-up, divide-by-zero override.
  always_comb begin
    r_mag = acc_nx[WIDTH+1] ? WIDTH'(acc_nx + m) : acc_nx[WIDTH-1:0];
    quot  = q_neg ? (~q_nx + WIDTH'(1)) : q_nx;
    rem   = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;
    if (b_zero) begin
      quot = '1;
      rem  = a_r;
    end
    res = div_r ? {quot, rem} : {acc_nx[WIDTH-1:0], q_nx};
    neg = div_r & quot[WIDTH-1];
    dz  = div_r & b_zero;
  end

endmodule

// File: rtl/seq_alu_core.sv
// Multi-cycle parametrised ALU: handshake FSM, combinational add/sub/shift/rotate,
// iterative mul/div engine, registered result held until downstream accepts it.
module seq_alu_core import alu_pkg::*; #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(2*WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [3:0]           opcode,
  input  logic [SHW-1:0]       shift,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry,
  output logic                 div_zero,
  output logic                 illegal
);

  localparam int KW = $clog2(WIDTH);

  alu_state_e             state;
  logic                   acc_go;
  logic [3:0]             op_r;
  logic [WIDTH-1:0]       a_r, b_r;
  logic [SHW-1:0]         sh_r;
  logic [WIDTH:0]         addsub;
  logic [2*WIDTH-1:0]     ab, rot2, res_sc;
  logic [KW-1:0]          rot_k;
  logic                   carry_sc, ill_sc;
  logic                   md_busy, md_done, md_neg, md_dz;
  logic [2*WIDTH-1:0]     md_res;

  assign acc_go = in_valid && in_ready;

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (acc_go && is_muldiv(opcode)),
    .is_div (opcode == DIV),
    .a      (a),
    .b      (b),
    .busy   (md_busy),
    .done   (md_done),
    .res    (md_res),
    .neg    (md_neg),
    .dz     (md_dz)
  );

  // Operand/opcode capture on an accepted beat.
  always_ff @(posedge clk) begin
    if (acc_go) begin
      op_r <= opcode;
      a_r  <= a;
      b_r  <= b;
      sh_r <= shift;
    end
  end

  // Single-cycle datapath. The shift field is SHW bits wide, so a funnel shift
  // never reaches 2*WIDTH and the plain shift already yields the zero-fill result.
  always_comb begin
    ab       = {a_r, b_r};
    rot_k    = sh_r[KW-1:0];
    rot2     = '0;
    addsub   = '0;
    res_sc   = '0;
    carry_sc = 1'b0;
    ill_sc   = 1'b0;
    case (op_r)
      ADD: begin
        addsub   = {1'b0, a_r} + {1'b0, b_r};
        res_sc   = {{(WIDTH-1){1'b0}}, addsub};
        carry_sc = addsub[WIDTH];
      end
      SUB: begin
        addsub   = {1'b0, a_r} + {1'b0, ~b_r} + (WIDTH+1)'(1);
        res_sc   = {{(WIDTH-1){1'b0}}, addsub};
        carry_sc = addsub[WIDTH];
      end
      FLS: res_sc = ab << sh_r;
      FRS: res_sc = ab >> sh_r;
      ROL: begin
        rot2   = {a_r, a_r} << rot_k;
        res_sc = {{WIDTH{1'b0}}, rot2[2*WIDTH-1:WIDTH]};
      end
      ROR: begin
        rot2   = {a_r, a_r} >> rot_k;
        res_sc = {{WIDTH{1'b0}}, rot2[WIDTH-1:0]};
      end
      MUL, DIV: res_sc = '0;
      default: ill_sc = 1'b1;
    endcase
  end

  // Handshake FSM with registered outputs; result captured on the last EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      div_zero  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= EXEC;
            in_ready <= 1'b0;
          end
        end
        EXEC: begin
          if (!md_busy || md_done) begin
            if (is_muldiv(op_r)) begin
              result   <= md_res;
              carry    <= md_neg;
              div_zero <= md_dz;
              illegal  <= 1'b0;
            end else begin
              result   <= res_sc;
              carry    <= carry_sc;
              div_zero <= 1'b0;
              illegal  <= ill_sc;
            end
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_core.sv
// Directed bench for seq_alu_core: WIDTH=32 vector table, multi-cycle corner
// sequences, and a WIDTH=8 instance for the narrow-width cases.
module tb_seq_alu_core;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        iv, ir, ov, ordy, c, dz, il;
  logic [31:0] a, b;
  logic [3:0]  op;
  logic [5:0]  sh;
  logic [63:0] res;

  logic        iv8, ir8, ov8, ordy8, c8, dz8, il8;
  logic [7:0]  a8, b8;
  logic [3:0]  op8;
  logic [3:0]  sh8;
  logic [15:0] res8;

  int checks = 0;
  int errors = 0;

  seq_alu_core #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
    .opcode(op), .shift(sh), .out_valid(ov), .out_ready(ordy), .result(res),
    .carry(c), .div_zero(dz), .illegal(il)
  );

  seq_alu_core #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .opcode(op8), .shift(sh8), .out_valid(ov8), .out_ready(ordy8), .result(res8),
    .carry(c8), .div_zero(dz8), .illegal(il8)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  sh;
    logic [63:0] res;
    logic        c;
    logic        z;
    logic        i;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl[NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic run32(input logic [3:0] o, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [5:0] ish, output int lat);
    @(negedge clk);
    chk("in_ready_idle32", 64'(ir), 64'(1));
    op = o; a = ia; b = ib; sh = ish; iv = 1'b1;
    @(posedge clk);
    #1 iv = 1'b0;
    lat = 1;
    while (!ov && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic pop32();
    @(negedge clk) ordy = 1'b1;
    @(posedge clk);
    #1 ordy = 1'b0;
  endtask

  task automatic run8(input logic [3:0] o, input logic [7:0] ia, input logic [7:0] ib, output int lat);
    @(negedge clk);
    chk("in_ready_idle8", 64'(ir8), 64'(1));
    op8 = o; a8 = ia; b8 = ib; sh8 = '0; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    lat = 1;
    while (!ov8 && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic pop8();
    @(negedge clk) ordy8 = 1'b1;
    @(posedge clk);
    #1 ordy8 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int exp_lat;
    logic [63:0] held;

    tbl[0]  = '{ADD,   32'hFFFF_FFFF, 32'h0000_0001, 6'd0,  64'h0000_0001_0000_0000, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{ADD,   32'h0000_0005, 32'h0000_0007, 6'd0,  64'h0000_0000_0000_000C, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{SUB,   32'h0000_0005, 32'h0000_0003, 6'd0,  64'h0000_0001_0000_0002, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{SUB,   32'h0000_0003, 32'h0000_0005, 6'd0,  64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{MUL,   32'hFFFF_FFFD, 32'h0000_0007, 6'd0,  64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{MUL,   32'h8000_0000, 32'h8000_0000, 6'd0,  64'h4000_0000_0000_0000, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{MUL,   32'h0000_3039, 32'hFFFF_FFFF, 6'd0,  64'hFFFF_FFFF_FFFF_CFC7, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{DIV,   32'hFFFF_FFF9, 32'h0000_0002, 6'd0,  64'hFFFF_FFFD_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{DIV,   32'h0000_0064, 32'h0000_0007, 6'd0,  64'h0000_000E_0000_0002, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{DIV,   32'h0000_0007, 32'hFFFF_FFFE, 6'd0,  64'hFFFF_FFFD_0000_0001, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 6'd0,  64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{FLS,   32'h0000_0001, 32'h8000_0000, 6'd1,  64'h0000_0003_0000_0000, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{FRS,   32'h8000_0000, 32'h0000_0000, 6'd63, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{FRS,   32'hDEAD_BEEF, 32'h1234_5678, 6'd0,  64'hDEAD_BEEF_1234_5678, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{ROR,   32'h0000_0001, 32'hFFFF_FFFF, 6'd33, 64'h0000_0000_8000_0000, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{ROL,   32'h8000_0001, 32'h0000_0000, 6'd4,  64'h0000_0000_0000_0018, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{ROL,   32'h1234_5678, 32'h0000_0000, 6'd32, 64'h0000_0000_1234_5678, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{4'd12, 32'h1234_5678, 32'h0000_0001, 6'd0,  64'h0000_0000_0000_0000, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{FLS,   32'h0000_0000, 32'h0000_0001, 6'd63, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    iv = 1'b0; ordy = 1'b0; a = '0; b = '0; op = '0; sh = '0;
    iv8 = 1'b0; ordy8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; sh8 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(ir),  64'(1));
    chk("rst_out_valid", 64'(ov),  64'(0));
    chk("rst_result",    res,      64'(0));
    chk("rst_flags",     64'({c, dz, il}), 64'(0));
    chk("rst_in_ready8", 64'(ir8), 64'(1));
    @(negedge clk) rst_n = 1'b1;

    // Table-driven WIDTH=32 vectors
    for (int k = 0; k < NV; k++) begin
      run32(tbl[k].op, tbl[k].a, tbl[k].b, tbl[k].sh, lat);
      exp_lat = (tbl[k].op == MUL || tbl[k].op == DIV) ? 33 : 2;
      chk($sformatf("v%0d_latency", k), 64'(lat), 64'(exp_lat));
      chk($sformatf("v%0d_result", k), res, tbl[k].res);
      chk($sformatf("v%0d_carry", k), 64'(c), 64'(tbl[k].c));
      chk($sformatf("v%0d_div_zero", k), 64'(dz), 64'(tbl[k].z));
      chk($sformatf("v%0d_illegal", k), 64'(il), 64'(tbl[k].i));
      pop32();
    end

    // MUL with result held for 5 cycles under out_ready=0
    run32(MUL, 32'hFFFF_FFFD, 32'h0000_0007, 6'd0, lat);
    chk("hold_latency", 64'(lat), 64'(33));
    held = 64'hFFFF_FFFF_FFFF_FFEB;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_result", k), res, held);
      chk($sformatf("hold%0d_in_ready", k), 64'(ir), 64'(0));
      chk($sformatf("hold%0d_out_valid", k), 64'(ov), 64'(1));
    end
    pop32();
    chk("hold_release_out_valid", 64'(ov), 64'(0));

    // Divide by zero
    run32(DIV, 32'h0000_0007, 32'h0000_0000, 6'd0, lat);
    chk("dz_latency", 64'(lat), 64'(33));
    chk("dz_result", res, 64'hFFFF_FFFF_0000_0007);
    chk("dz_div_zero", 64'(dz), 64'(1));
    chk("dz_illegal", 64'(il), 64'(0));
    pop32();

    // Reset asserted on cycle 10 of a DIV
    @(negedge clk);
    op = DIV; a = 32'd100; b = 32'd3; sh = '0; iv = 1'b1;
    @(posedge clk);
    #1 iv = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(ov), 64'(0));
    chk("abort_in_ready",  64'(ir), 64'(1));
    chk("abort_result",    res,     64'(0));
    chk("abort_flags",     64'({c, dz, il}), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    run32(ADD, 32'd20, 32'd22, 6'd0, lat);
    chk("post_abort_latency", 64'(lat), 64'(2));
    chk("post_abort_result",  res, 64'd42);
    chk("post_abort_carry",   64'(c), 64'(0));
    pop32();

    // WIDTH=8 instance
    run8(MUL, 8'h80, 8'h80, lat);
    chk("w8_mul_latency", 64'(lat), 64'(9));
    chk("w8_mul_result", 64'(res8), 64'h4000);
    chk("w8_mul_carry", 64'(c8), 64'(0));
    pop8();
    run8(DIV, 8'h80, 8'hFF, lat);
    chk("w8_div_latency", 64'(lat), 64'(9));
    chk("w8_div_result", 64'(res8), 64'h8000);
    chk("w8_div_carry", 64'(c8), 64'(1));
    chk("w8_div_div_zero", 64'(dz8), 64'(0));
    pop8();
    run8(4'd9, 8'h12, 8'h34, lat);
    chk("w8_ill_latency", 64'(lat), 64'(2));
    chk("w8_ill_result", 64'(res8), 64'h0000);
    chk("w8_ill_illegal", 64'(il8), 64'(1));
    pop8();
    run8(ADD, 8'hFF, 8'h01, lat);
    chk("w8_add_result", 64'(res8), 64'h0100);
    chk("w8_add_carry", 64'(c8), 64'(1));
    pop8();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
